pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end of the MIPS32 pipeline. Holds the program counter and drives the address and enable of the combinational instruction ROM. Registers the returned word, together with its PC, into the IF/ID pipeline register. Handles sequential increment, delayed-slot branch redirect, exception flush and pipeline stalls, and remembers a redirect that arrives while fetch is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, default 32'h0000_0000: instruction word inserted as a bubble.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc_o` output 32: fetch address to the ROM.
- `ce_o` output 1: fetch enable; 0 means the ROM word is ignored.
- `inst_i` input 32: ROM data for `pc_o`, combinational, same cycle.
- `stall_if_i` input 1: hold PC; fetch stage frozen.
- `stall_id_i` input 1: hold the IF/ID register. Controller guarantees `stall_id_i` implies `stall_if_i`.
- `branch_flag_i` input 1: one-cycle pulse from ID; redirect fetch.
- `branch_target_i` input 32: redirect address, valid with `branch_flag_i`.
- `flush_i` input 1: exception flush; kill IF/ID and redirect.
- `flush_pc_i` input 32: handler address, valid with `flush_i`.
- `id_pc_o` output 32: IF/ID PC.
- `id_inst_o` output 32: IF/ID instruction.
- `id_valid_o` output 1: IF/ID holds a real instruction.

## Operation
- States:
  - IDLE: entered on reset, `ce_o`=0.
  - RUN: `ce_o`=1.
  - IDLE→RUN on the first edge with `rst`=0. No other transitions except `rst`→IDLE from any state.
- PC next-value priority (RUN only): `rst` > `flush_i` > `stall_if_i` > pending redirect > `branch_flag_i` > `pc_o`+4.
  - `flush_i`: `pc_o` ← `flush_pc_i`. Clears pending.
  - `stall_if_i`: `pc_o` holds. If `branch_flag_i`=1, latch `branch_target_i` into the pending register and set the pending flag. A newer branch overwrites an older pending one.
  - Pending set and not stalled: `pc_o` ← pending target; pending cleared.
  - `branch_flag_i` and not stalled: `pc_o` ← `branch_target_i`.
  - PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. Low two bits are carried unmodified.
- In IDLE, `pc_o` holds `RESET_PC`; branch and flush inputs are ignored.
- IF/ID register priority: `rst` > `flush_i` > `stall_id_i` > (`stall_if_i` & !`stall_id_i`) > capture.
  - `rst`/`flush_i`: pc=0, inst=`NOP_INST`, valid=0.
  - `stall_id_i`: hold all three.
  - IF stalled, ID not: bubble (pc=0, inst=`NOP_INST`, valid=0).
  - Capture: `id_pc_o` ← `pc_o`, `id_inst_o` ← `inst_i`, `id_valid_o` ← `ce_o`. When `ce_o`=0, inst ← `NOP_INST`.
- Branch delay slot: a branch does NOT kill IF/ID. The word fetched in the branch cycle is the delay slot and is captured normally.

## Timing
- Reset values: `pc_o`=`RESET_PC`, `ce_o`=0, `id_pc_o`=0, `id_inst_o`=`NOP_INST`, `id_valid_o`=0. Pending flag is 0.
- First edge after reset release: `ce_o`=1, `pc_o`=`RESET_PC`.
- Second edge: IF/ID holds `RESET_PC`/`rom[RESET_PC]` with valid=1, and `pc_o`=`RESET_PC`+4.
- Fetch-to-IF/ID latency is 1 cycle. Sustained throughput is 1 instruction/cycle.
- Redirect latency: branch pulse at edge N-1 → `pc_o`=target after edge N. The target instruction is in IF/ID after edge N+1.
- Pending redirect takes effect on the first edge where `stall_if_i`=0.
- `flush_i` concurrent with a stall or branch: flush wins, stall ignored for that edge.
- `rst` mid-operation returns to IDLE at the next edge and discards pending.

## Test plan
- Reset then run, `RESET_PC`=0, ROM {A,B,C} → `pc_o` sequence 0,0,4,8. IF/ID shows (0,A,1), (4,B,1), (8,C,1). `id_valid_o`=0 before that.
- Branch pulse with target 0x40 while `pc_o`=0x8 → IF/ID gets (0x8, delay-slot word, 1), then `pc_o`=0x40, then IF/ID gets (0x40, rom[0x40], 1).
- `stall_if_i`=`stall_id_i`=1 for 3 cycles at `pc_o`=0x10 → `pc_o` and IF/ID frozen. A branch to 0x80 during the stall → first unstalled edge sets `pc_o`=0x80.
- `stall_if_i`=1, `stall_id_i`=0 for 1 cycle → IF/ID becomes (0, `NOP_INST`, 0) and `pc_o` holds.
- `flush_i` with `flush_pc_i`=0x180, concurrent with `branch_flag_i` and a pending redirect → `pc_o`=0x180, IF/ID bubble, pending cleared.
- `pc_o`=0xFFFF_FFFC with no stall → next `pc_o`=0x0000_0000. `rst` pulsed mid-run → all outputs return to reset values next edge.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: MIPS32 instruction-fetch front end.
// Holds the program counter, drives the instruction ROM address/enable and
// registers the returned word with its PC into the IF/ID pipeline register.
// Handles sequential fetch, delay-slot branch redirect, exception flush,
// IF/ID stalls and a redirect that arrives while fetch is frozen.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | held in / just out of reset; ROM disabled, PC = RESET_PC
//  S_RUN  | fetching; ROM enabled every cycle, stalled or not
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        ce_o,
  input  logic [31:0] inst_i,
  input  logic        stall_if_i,
  input  logic        stall_id_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  logic        run;

  assign run = (state_q == S_RUN);

  // Next fetch state: PC selection and the deferred-redirect register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (!run) begin
      // Branch and flush have no effect until fetch is running.
      state_d = S_RUN;
      pc_d    = RESET_PC;
    end else if (flush_i) begin
      pc_d   = flush_pc_i;
      pend_d = 1'b0;
    end else if (stall_if_i) begin
      // Remember the latest redirect; an older pending one is overwritten.
      if (branch_flag_i) begin
        pend_d    = 1'b1;
        pend_pc_d = branch_target_i;
      end
    end else if (pend_q) begin
      // A deferred redirect outranks a branch presented in the same cycle.
      pc_d   = pend_pc_q;
      pend_d = 1'b0;
    end else if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else begin
      pc_d = pc_q + 32'd4;
    end
    ce_d = (state_d == S_RUN);
  end

  // Next IF/ID contents: flush, hold, bubble or capture of the fetched word.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (run && flush_i) begin
      id_pc_d    = 32'd0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (stall_id_i) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (stall_if_i) begin
      id_pc_d    = 32'd0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      // A branch does not kill IF/ID: the word fetched now is the delay slot.
      id_pc_d    = pc_q;
      id_inst_d  = ce_q ? inst_i : NOP_INST;
      id_valid_d = ce_q;
    end
  end

  // Fetch FSM, PC and pending-redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ce_q      <= 1'b0;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // IF/ID pipeline register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q    <= 32'd0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed vector table followed by randomized
// stimulus compared against a cycle-level behavioural model.
module tb_pc_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i;
  logic        stall_if_i;
  logic        stall_id_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int n_tot  = 0;
  int n_pass = 0;

  pc_fetch #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .ce_o(ce_o), .inst_i(inst_i),
    .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
  endfunction

  assign inst_i = rom(pc_o);

  typedef struct {
    logic        r, sif, sid, br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] fp;
    logic [31:0] e_pc;
    logic        e_ce;
    logic [31:0] e_ipc, e_iinst;
    logic        e_iv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, sif, sid, br, input logic [31:0] bt,
                     input logic fl, input logic [31:0] fp, ep,
                     input logic ec, input logic [31:0] ipc, iinst,
                     input logic iv);
    vec_t v;
    v.r = r; v.sif = sif; v.sid = sid; v.br = br; v.bt = bt;
    v.fl = fl; v.fp = fp; v.e_pc = ep; v.e_ce = ec;
    v.e_ipc = ipc; v.e_iinst = iinst; v.e_iv = iv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, sif, sid, br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] fp);
    rst = r; stall_if_i = sif; stall_id_i = sid; branch_flag_i = br;
    branch_target_i = bt; flush_i = fl; flush_pc_i = fp;
  endtask

  // behavioural model state
  logic        m_run, m_pend;
  logic [31:0] m_pc, m_ptgt, m_ipc, m_iinst;
  logic        m_iv;

  task automatic model_step();
    logic [31:0] cur;
    cur = m_pc;
    if (rst) begin
      m_run = 0; m_pc = RPC; m_pend = 0; m_ptgt = 0;
      m_ipc = 0; m_iinst = NOP; m_iv = 0;
    end else if (!m_run) begin
      m_run = 1;
      if (stall_id_i) ;
      else if (stall_if_i) begin m_ipc = 0; m_iinst = NOP; m_iv = 0; end
      else begin m_ipc = cur; m_iinst = NOP; m_iv = 0; end
    end else begin
      if (flush_i) begin m_ipc = 0; m_iinst = NOP; m_iv = 0; end
      else if (stall_id_i) ;
      else if (stall_if_i) begin m_ipc = 0; m_iinst = NOP; m_iv = 0; end
      else begin m_ipc = cur; m_iinst = rom(cur); m_iv = 1; end
      if (flush_i) begin m_pc = flush_pc_i; m_pend = 0; end
      else if (stall_if_i) begin
        if (branch_flag_i) begin m_pend = 1; m_ptgt = branch_target_i; end
      end else if (m_pend) begin m_pc = m_ptgt; m_pend = 0; end
      else if (branch_flag_i) m_pc = branch_target_i;
      else m_pc = cur + 32'd4;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    m_run = 0; m_pend = 0; m_pc = RPC; m_ptgt = 0;
    m_ipc = 0; m_iinst = NOP; m_iv = 0;

    //   r sif sid br bt            fl fp     | pc           ce  id_pc         id_inst             v
    add(1, 0, 0, 0, 0,             0, 0,     32'h0,         0, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h0,         1, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h4,         1, 32'h0,        rom(32'h0),         1);
    add(0, 0, 0, 0, 0,             0, 0,     32'h8,         1, 32'h4,        rom(32'h4),         1);
    add(0, 0, 0, 1, 32'h40,        0, 0,     32'h40,        1, 32'h8,        rom(32'h8),         1);
    add(0, 0, 0, 1, 32'h10,        0, 0,     32'h10,        1, 32'h40,       rom(32'h40),        1);
    add(0, 1, 1, 0, 0,             0, 0,     32'h10,        1, 32'h40,       rom(32'h40),        1);
    add(0, 1, 1, 1, 32'h80,        0, 0,     32'h10,        1, 32'h40,       rom(32'h40),        1);
    add(0, 1, 1, 0, 0,             0, 0,     32'h10,        1, 32'h40,       rom(32'h40),        1);
    add(0, 0, 0, 0, 0,             0, 0,     32'h80,        1, 32'h10,       rom(32'h10),        1);
    add(0, 1, 0, 0, 0,             0, 0,     32'h80,        1, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h84,        1, 32'h80,       rom(32'h80),        1);
    add(0, 1, 1, 1, 32'h200,       0, 0,     32'h84,        1, 32'h80,       rom(32'h80),        1);
    add(0, 1, 1, 1, 32'h300,       1, 32'h180, 32'h180,     1, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h184,       1, 32'h180,      rom(32'h180),       1);
    add(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0,     32'hFFFF_FFFC, 1, 32'h184,      rom(32'h184),       1);
    add(0, 0, 0, 0, 0,             0, 0,     32'h0,         1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1);
    add(0, 1, 1, 1, 32'h500,       0, 0,     32'h0,         1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1);
    add(1, 0, 0, 0, 0,             0, 0,     32'h0,         0, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h0,         1, 32'h0,        NOP,                0);
    add(0, 0, 0, 0, 0,             0, 0,     32'h4,         1, 32'h0,        rom(32'h0),         1);
    add(0, 0, 0, 1, 32'h13,        0, 0,     32'h13,        1, 32'h4,        rom(32'h4),         1);
    add(0, 0, 0, 0, 0,             0, 0,     32'h17,        1, 32'h13,       rom(32'h13),        1);
    add(0, 1, 1, 1, 32'h60,        0, 0,     32'h17,        1, 32'h13,       rom(32'h13),        1);
    add(0, 0, 0, 1, 32'h70,        0, 0,     32'h60,        1, 32'h17,       rom(32'h17),        1);
    add(0, 0, 0, 0, 0,             0, 0,     32'h64,        1, 32'h60,       rom(32'h60),        1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].sif, tbl[i].sid, tbl[i].br, tbl[i].bt,
            tbl[i].fl, tbl[i].fp);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc_o", i), pc_o, tbl[i].e_pc);
      chk($sformatf("vec%0d ce_o", i), {31'd0, ce_o}, {31'd0, tbl[i].e_ce});
      chk($sformatf("vec%0d id_pc_o", i), id_pc_o, tbl[i].e_ipc);
      chk($sformatf("vec%0d id_inst_o", i), id_inst_o, tbl[i].e_iinst);
      chk($sformatf("vec%0d id_valid_o", i), {31'd0, id_valid_o}, {31'd0, tbl[i].e_iv});
    end

    // randomized phase against the behavioural model
    for (int c = 0; c < 3000; c++) begin
      logic        r, sif, sid, br, fl;
      logic [31:0] bt, fp;
      r   = (c == 0) || ($urandom_range(0, 63) == 0);
      sif = ($urandom_range(0, 2) == 0);
      sid = sif && $urandom_range(0, 1);
      br  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      bt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_FFFF);
      fp  = $urandom & 32'h0000_0FFC;
      drive(r, sif, sid, br, bt, fl, fp);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d pc_o", c), pc_o, m_pc);
      chk($sformatf("rnd%0d ce_o", c), {31'd0, ce_o}, {31'd0, m_run});
      chk($sformatf("rnd%0d id_pc_o", c), id_pc_o, m_ipc);
      chk($sformatf("rnd%0d id_inst_o", c), id_inst_o, m_iinst);
      chk($sformatf("rnd%0d id_valid_o", c), {31'd0, id_valid_o}, {31'd0, m_iv});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
